// File: rtl/bcd_ctrl_defs.sv
// Shared definitions for the two-digit BCD counter controller:
// state encodings, digit width and the BCD validity helper.
package bcd_ctrl_defs;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_bcd_pair(input logic [7:0] v);
    return (v[7:4] <= BCD_MAX_DIGIT) && (v[3:0] <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit register with clear/load/inc/dec controls.
// carry/borrow flag the 9->0 and 0->9 rollovers so the next digit can be gated.
module bcd_digit
  import bcd_ctrl_defs::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               inc,
  input  logic               dec,
  output logic [DIGIT_W-1:0] value,
  output logic               carry,
  output logic               borrow
);

  assign carry  = inc && (value == BCD_MAX_DIGIT);
  assign borrow = dec && (value == 4'd0);

  // digit register: clear beats load beats counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (ld) begin
      value <= ld_val;
    end else if (inc) begin
      value <= (value == BCD_MAX_DIGIT) ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      value <= (value == 4'd0) ? BCD_MAX_DIGIT : value - 4'd1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/bcd_counter_controller.sv
// Run/pause/clear/load controller for a 00-99 BCD counter with a tick
// prescaler, wrap/stop terminal policy and a two-slot multiplexed digit output.
module bcd_counter_controller
  import bcd_ctrl_defs::*;
#(
  parameter int TICK_DIV = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       up,
  input  logic       wrap_en,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic       tick,
  output logic       wrap,
  output logic       load_err,
  output logic [1:0] state,
  output logic       digit_sel,
  output logic [3:0] disp_digit
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t        st;
  logic [PW-1:0] presc;
  logic [SW-1:0] scan;

  logic load_ok, terminal, step_edge, quiet;
  logic do_clear, do_load, do_stop, do_start;
  logic step_ok, step_blocked;
  logic units_carry, units_borrow, tens_carry, tens_borrow;

  assign state = st;

  // control arbitration and step qualification
  always_comb begin
    load_ok      = is_bcd_pair(load_val);
    terminal     = up ? ((units == 4'd9) && (tens == 4'd9))
                      : ((units == 4'd0) && (tens == 4'd0));
    do_clear     = clear;
    do_load      = !clear && load;
    do_stop      = !clear && !load && stop;
    do_start     = !clear && !load && !stop && start;
    quiet        = !clear && !load && !stop;
    step_edge    = (st == ST_RUN) && (presc == PRE_LAST);
    step_ok      = step_edge && quiet && (wrap_en || !terminal);
    step_blocked = step_edge && quiet && !wrap_en && terminal;
  end

  bcd_digit u_units (
    .clk(clk), .reset(reset), .clr(do_clear), .ld(do_load && load_ok),
    .ld_val(load_val[3:0]), .inc(step_ok && up), .dec(step_ok && !up),
    .value(units), .carry(units_carry), .borrow(units_borrow)
  );

  bcd_digit u_tens (
    .clk(clk), .reset(reset), .clr(do_clear), .ld(do_load && load_ok),
    .ld_val(load_val[7:4]), .inc(units_carry), .dec(units_borrow),
    .value(tens), .carry(tens_carry), .borrow(tens_borrow)
  );

  // FSM, prescaler and status pulses; the tens rollover marks a full wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= ST_IDLE;
      presc    <= '0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= step_ok;
      wrap     <= tens_carry || tens_borrow;
      load_err <= do_load && !load_ok;
      if (do_clear) begin
        st    <= ST_IDLE;
        presc <= '0;
      end else if (do_load) begin
        if (load_ok) begin
          presc <= '0;
          st    <= (st == ST_DONE) ? ST_PAUSE : st;
        end else begin
          presc <= presc;
        end
      end else if (do_stop) begin
        st <= (st == ST_RUN) ? ST_PAUSE : st;
      end else if (do_start) begin
        case (st)
          ST_IDLE, ST_PAUSE: st <= ST_RUN;
          ST_DONE:           st <= (wrap_en || !terminal) ? ST_RUN : ST_DONE;
          default:           st <= st;
        endcase
      end else if (st == ST_RUN) begin
        if (presc == PRE_LAST) begin
          presc <= '0;
          st    <= step_blocked ? ST_DONE : ST_RUN;
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= presc;
      end
    end
  end

  // free-running display scan; disp_digit lags digit_sel by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan       <= '0;
      digit_sel  <= 1'b0;
      disp_digit <= 4'd0;
    end else begin
      disp_digit <= digit_sel ? tens : units;
      if (scan == SCAN_LAST) begin
        scan      <= '0;
        digit_sel <= !digit_sel;
      end else begin
        scan <= scan + SW'(1);
      end
    end
  end

endmodule
